// File: rtl/bkg_pkg.sv
// Shared constants and types for the scrolling, tiled background fetch path.
package bkg_pkg;

  localparam int IMG_W = 160;
  localparam int IMG_H = 160;
  localparam int SCR_W = 640;
  localparam int SCR_H = 480;
  localparam int TILE  = 320;

  typedef logic [9:0] coord_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef enum logic {
    SCROLL_IDLE  = 1'b0,
    SCROLL_APPLY = 1'b1
  } scroll_state_e;

  // (off - amt) mod TILE; off < TILE and amt <= 255 so one correction is enough
  function automatic logic [8:0] scroll_sub(input logic [8:0] off, input logic [7:0] amt);
    if ({1'b0, amt} <= off)
      return off - {1'b0, amt};
    else
      return off + (9'(TILE) - {1'b0, amt});
  endfunction

endpackage

// File: rtl/bkg_addr_gen.sv
// Combinational pixel-to-texel address: wrap into the tile, downscale, then y*IMG_W + x.
import bkg_pkg::*;

module bkg_addr_gen #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 160,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 15
) (
  input  logic [9:0]        draw_x,
  input  logic [9:0]        draw_y,
  input  logic [8:0]        offset,
  output logic [ADDR_W-1:0] addr
);

  localparam logic [9:0] TILE_X = 10'(IMG_W << SCALE_SHIFT);
  localparam logic [9:0] TILE_Y = 10'(IMG_H << SCALE_SHIFT);

  coord_t ys_raw, ys_wrap1, ys, xs, x_img, y_img;
  logic [ADDR_W-1:0] x_ext, y_ext;

  // ys_raw tops out at 479 + 319 = 798, so two conditional subtracts cover it
  assign ys_raw   = draw_y + {1'b0, offset};
  assign ys_wrap1 = (ys_raw >= TILE_Y) ? ys_raw - TILE_Y : ys_raw;
  assign ys       = (ys_wrap1 >= TILE_Y) ? ys_wrap1 - TILE_Y : ys_wrap1;
  assign xs       = (draw_x >= TILE_X) ? draw_x - TILE_X : draw_x;

  assign x_img = xs >> SCALE_SHIFT;
  assign y_img = ys >> SCALE_SHIFT;
  assign x_ext = ADDR_W'(x_img);
  assign y_ext = ADDR_W'(y_img);

  generate
    if (IMG_W == 160) begin : g_mul160
      assign addr = (y_ext << 7) + (y_ext << 5) + x_ext;
    end else begin : g_mul
      assign addr = y_ext * ADDR_W'(IMG_W) + x_ext;
    end
  endgenerate

endmodule

// File: rtl/bkg_scroll_fetch.sv
// Background fetch pipeline: scroll FSM, address stage, RAM stage, output stage (3-cycle latency).
// Optional build macro BKG_DIM_EN halves every colour channel while dim is high.
import bkg_pkg::*;

module bkg_scroll_fetch #(
  parameter int IMG_W       = 160,
  parameter int IMG_H       = 160,
  parameter int SCALE_SHIFT = 1,
  parameter int ADDR_W      = 15
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              VS,
  input  logic [7:0]        scroll_amt,
  input  logic              dim,
  output logic [ADDR_W-1:0] read_address,
  input  logic [23:0]       ram_data,
  output logic [23:0]       bkg_rgb,
  output logic [9:0]        out_x,
  output logic [9:0]        out_y,
  output logic              out_active,
  output logic [8:0]        scroll_offset
);

  scroll_state_e     state_reg, state_next;
  logic              vs_prev_reg;
  logic [8:0]        offset_next;
  logic [ADDR_W-1:0] addr_next;
  coord_t            x1_reg, y1_reg, x2_reg, y2_reg;
  logic              act1_reg, act2_reg;
  rgb_t              pix_next;

  bkg_addr_gen #(
    .IMG_W       (IMG_W),
    .IMG_H       (IMG_H),
    .SCALE_SHIFT (SCALE_SHIFT),
    .ADDR_W      (ADDR_W)
  ) u_addr_gen (
    .draw_x (DrawX),
    .draw_y (DrawY),
    .offset (scroll_offset),
    .addr   (addr_next)
  );

  always_comb begin
    state_next  = state_reg;
    offset_next = scroll_offset;
    case (state_reg)
      SCROLL_IDLE: begin
        if (vs_prev_reg && !VS)
          state_next = SCROLL_APPLY;
      end
      SCROLL_APPLY: begin
        offset_next = scroll_sub(scroll_offset, scroll_amt);
        state_next  = SCROLL_IDLE;
      end
      default: state_next = SCROLL_IDLE;
    endcase
  end

`ifdef BKG_DIM_EN
  logic [23:0] dimmed;
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_dim
      assign dimmed[gi*8 +: 8] = {1'b0, ram_data[gi*8+1 +: 7]};
    end
  endgenerate
  assign pix_next = act2_reg ? rgb_t'(dim ? dimmed : ram_data) : '0;
`else
  logic unused_dim;
  assign unused_dim = dim;
  assign pix_next   = act2_reg ? rgb_t'(ram_data) : '0;
`endif

  // VS history is tracked in every state so a held-low VS never re-arms the update
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_reg     <= SCROLL_IDLE;
      vs_prev_reg   <= 1'b0;
      scroll_offset <= '0;
      read_address  <= '0;
      x1_reg        <= '0;
      y1_reg        <= '0;
      act1_reg      <= 1'b0;
      x2_reg        <= '0;
      y2_reg        <= '0;
      act2_reg      <= 1'b0;
      bkg_rgb       <= '0;
      out_x         <= '0;
      out_y         <= '0;
      out_active    <= 1'b0;
    end else begin
      state_reg     <= state_next;
      vs_prev_reg   <= VS;
      scroll_offset <= offset_next;
      read_address  <= addr_next;
      x1_reg        <= DrawX;
      y1_reg        <= DrawY;
      act1_reg      <= blank;
      x2_reg        <= x1_reg;
      y2_reg        <= y1_reg;
      act2_reg      <= act1_reg;
      bkg_rgb       <= pix_next;
      out_x         <= x2_reg;
      out_y         <= y2_reg;
      out_active    <= act2_reg;
    end
  end

endmodule

// File: tb/tb_bkg_scroll_fetch.sv
// Randomized self-checking bench for bkg_scroll_fetch against a texel-arithmetic reference model.
`timescale 1ns/1ps

module tb_bkg_scroll_fetch;

`ifdef BKG_DIM_EN
  localparam bit DIM_BUILD = 1'b1;
`else
  localparam bit DIM_BUILD = 1'b0;
`endif

  logic        Clk = 1'b0;
  logic        Reset_n;
  logic [9:0]  DrawX, DrawY;
  logic        blank, VS, dim;
  logic [7:0]  scroll_amt;
  logic [14:0] read_address;
  logic [23:0] ram_data = 24'h0;
  logic [23:0] bkg_rgb;
  logic [9:0]  out_x, out_y;
  logic        out_active;
  logic [8:0]  scroll_offset;

  logic [23:0] mem [0:25599];
  int          n_checks = 0;
  int          n_pass   = 0;
  int          model_off = 0;
  int          px_x [0:63];
  int          px_y [0:63];
  bit          px_a [0:63];
  bit          px_d [0:65];

  always #5 Clk = ~Clk;

  always @(posedge Clk)
    ram_data <= (read_address < 15'd25600) ? mem[read_address] : 24'h0;

  bkg_scroll_fetch dut (
    .Clk           (Clk),
    .Reset_n       (Reset_n),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .VS            (VS),
    .scroll_amt    (scroll_amt),
    .dim           (dim),
    .read_address  (read_address),
    .ram_data      (ram_data),
    .bkg_rgb       (bkg_rgb),
    .out_x         (out_x),
    .out_y         (out_y),
    .out_active    (out_active),
    .scroll_offset (scroll_offset)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // screen pixel -> texel index: wrap each axis into the 320-pixel tile, halve, row-major
  function automatic int model_addr(input int x, input int y, input int off);
    return (((y + off) % 320) / 2) * 160 + (x % 320) / 2;
  endfunction

  function automatic logic [23:0] model_pix(input logic [23:0] raw, input bit act, input bit dm);
    logic [7:0] r, g, b;
    if (!act) return 24'h0;
    r = raw[23:16];
    g = raw[15:8];
    b = raw[7:0];
    if (DIM_BUILD && dm) begin
      r = r / 8'd2;
      g = g / 8'd2;
      b = b / 8'd2;
    end
    return {r, g, b};
  endfunction

  // caller is at a negedge; item i is presented, its address checked after one edge, pixel after three
  task automatic run_stream(input int n, input bit after_reset);
    int exp_addr [0:63];
    logic [23:0] exp_pix;
    int k;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin
        DrawX = 10'(px_x[i]);
        DrawY = 10'(px_y[i]);
        blank = px_a[i];
        exp_addr[i] = model_addr(px_x[i], px_y[i], model_off);
      end else begin
        blank = 1'b0;
      end
      dim = px_d[i];
      @(posedge Clk);
      @(negedge Clk);
      if (i < n) check_val("read_address", 32'(read_address), 32'(exp_addr[i]));
      if (i >= 2) begin
        k = i - 2;
        exp_pix = model_pix(mem[exp_addr[k]], px_a[k], px_d[i]);
        check_val("bkg_rgb", 32'(bkg_rgb), 32'(exp_pix));
        check_val("out_x", 32'(out_x), 32'(px_x[k]));
        check_val("out_y", 32'(out_y), 32'(px_y[k]));
        check_val("out_active", 32'(out_active), 32'(px_a[k]));
        $display("px x=%0d y=%0d act=%0b dim=%0b addr=%0d rgb=%06h exp=%06h",
                 px_x[k], px_y[k], px_a[k], px_d[i], exp_addr[k], bkg_rgb, exp_pix);
      end else if (after_reset) begin
        check_val("flush_active", 32'(out_active), 32'h0);
        check_val("flush_rgb", 32'(bkg_rgb), 32'h0);
      end
    end
  endtask

  task automatic fill_random(input int n);
    for (int i = 0; i < n; i++) begin
      px_x[i] = int'($urandom_range(639, 0));
      px_y[i] = int'($urandom_range(479, 0));
      px_a[i] = 1'($urandom);
    end
    for (int i = 0; i < n + 2; i++) px_d[i] = 1'($urandom);
  endtask

  // caller is at a negedge with VS high for at least one prior edge
  task automatic vsync(input int amt);
    scroll_amt = 8'(amt);
    VS = 1'b0;
    @(posedge Clk);
    @(negedge Clk);
    check_val("offset_before_apply", 32'(scroll_offset), 32'(model_off));
    model_off = ((model_off - amt) % 320 + 320) % 320;
    @(posedge Clk);
    @(negedge Clk);
    check_val("offset_apply", 32'(scroll_offset), 32'(model_off));
    $display("vsync amt=%0d offset=%0d exp=%0d", amt, scroll_offset, model_off);
    repeat (100) @(negedge Clk);
    check_val("offset_vs_held_low", 32'(scroll_offset), 32'(model_off));
    VS = 1'b1;
    scroll_amt = 8'($urandom);
    repeat (3) @(negedge Clk);
    check_val("offset_vs_high", 32'(scroll_offset), 32'(model_off));
  endtask

  initial begin
    int amt;
    for (int i = 0; i < 25600; i++) mem[i] = 24'($urandom);
    mem[162] = 24'hAABBCC;
    mem[800] = 24'hFF8040;

    Reset_n = 1'b0;
    DrawX = 10'd100;
    DrawY = 10'd0;
    blank = 1'b1;
    VS = 1'b1;
    scroll_amt = 8'd0;
    dim = 1'b0;
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    check_val("rst_read_address", 32'(read_address), 32'h0);
    check_val("rst_bkg_rgb", 32'(bkg_rgb), 32'h0);
    check_val("rst_out_x", 32'(out_x), 32'h0);
    check_val("rst_out_y", 32'(out_y), 32'h0);
    check_val("rst_out_active", 32'(out_active), 32'h0);
    check_val("rst_scroll_offset", 32'(scroll_offset), 32'h0);
    Reset_n = 1'b1;

    // unscrolled: active and blanked copy of one texel, plus horizontal tile wrap
    px_x[0] = 5;   px_y[0] = 3; px_a[0] = 1'b1;
    px_x[1] = 5;   px_y[1] = 3; px_a[1] = 1'b0;
    px_x[2] = 330; px_y[2] = 0; px_a[2] = 1'b1;
    px_x[3] = 639; px_y[3] = 0; px_a[3] = 1'b1;
    for (int i = 0; i < 6; i++) px_d[i] = 1'b0;
    run_stream(4, 1'b1);

    vsync(10);
    // scrolled to 310: single and double vertical wrap, dim requested throughout
    px_x[0] = 0; px_y[0] = 20;  px_a[0] = 1'b1;
    px_x[1] = 0; px_y[1] = 479; px_a[1] = 1'b1;
    for (int i = 0; i < 4; i++) px_d[i] = 1'b1;
    run_stream(2, 1'b0);

    for (int r = 0; r < 4; r++) begin
      amt = (r == 0) ? 255 : (r == 1) ? 0 : int'($urandom_range(255, 0));
      vsync(amt);
      fill_random(40);
      run_stream(40, 1'b0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/bkg_scroll_fetch.md
Name: bkg_scroll_fetch

Overview:
- Sits directly upstream of the 160x160, 24-bit background RAM.
- Converts the VGA controller's DrawX/DrawY into RAM read addresses, with 2x upscale, tiling, and vertical scrolling driven by the doodle's climb.
- Consumes the RAM's registered read data and delivers a pipeline-aligned background pixel, with coordinates and blanking, to the colour mapper.

Parameters:
- IMG_W, 160, background image width in texels
- IMG_H, 160, background image height in texels
- SCALE_SHIFT, 1, log2 upscale factor; tile period = IMG_W<<SCALE_SHIFT (320)
- ADDR_W, 15, RAM address width

Ports:
- Clk  in  1  system/pixel clock
- Reset_n  in  1  synchronous, active-low reset
- DrawX  in  10  current pixel column, 0..639
- DrawY  in  10  current pixel row, 0..479
- blank  in  1  1 = active video (VGA controller convention)
- VS  in  1  vertical sync, active-low
- scroll_amt  in  8  rows to scroll at the next frame boundary, 0..255
- dim  in  1  dim request; used only with BKG_DIM_EN
- read_address  out  15  to background RAM read port
- ram_data  in  24  RAM data_Out, valid 1 cycle after read_address
- bkg_rgb  out  24  background pixel {R,G,B}
- out_x  out  10  DrawX delayed to align with bkg_rgb
- out_y  out  10  DrawY delayed to align with bkg_rgb
- out_active  out  1  blank delayed to align with bkg_rgb
- scroll_offset  out  9  current vertical offset, 0..319

Behaviour:
- Reset: while Reset_n=0 at a rising edge, all outputs and internal registers go to 0: read_address, bkg_rgb, out_x, out_y, out_active, scroll_offset, and the VS history. Reset mid-frame discards in-flight pixels.
- Scroll FSM, states IDLE and APPLY:
  - IDLE: registers VS each cycle. A falling edge (prev=1, cur=0) moves to APPLY.
  - APPLY, one cycle: scroll_offset <= (scroll_offset − scroll_amt) mod 320. If scroll_amt ≤ offset, subtract; else offset + 320 − scroll_amt. Then return to IDLE.
  - Exactly one update per frame. VS held low does not re-trigger. scroll_amt=0 leaves the offset unchanged.
- Address stage (cycle 1, registered):
  - ys = DrawY + scroll_offset, 10 bits, max 798.
  - Subtract 320 while ys ≥ 320, at most twice, combinational.
  - xs = DrawX; subtract 320 once if xs ≥ 320.
  - x_img = xs>>SCALE_SHIFT; y_img = ys>>SCALE_SHIFT.
  - read_address = y_img*160 + x_img, computed as (y_img<<7)+(y_img<<5)+x_img. Max 25599, no overflow of 15 bits.
  - DrawX/DrawY/blank are registered alongside.
- RAM stage (cycle 2): the RAM returns ram_data. Coordinates and blank are delayed one more stage.
- Output stage (cycle 3, registered):
  - bkg_rgb = out_active ? ram_data : 24'h0.
  - out_x/out_y/out_active are aligned with bkg_rgb.
- Latency: exactly 3 cycles from DrawX/DrawY to bkg_rgb. Throughput is one pixel per clock, with no stalls.
- Offset update vs. fetch in the same cycle: the address stage uses the pre-update offset; the new offset applies from the next cycle. VS falls during blanking, so no visible tearing.
- Blanked pixels still issue reads (harmless) but output 0.

Optional Feature:
- Macro: BKG_DIM_EN.
- With BKG_DIM_EN defined: when dim=1 (sampled at the output stage), each 8-bit channel is right-shifted by 1 (e.g. FF8040 -> 7F4020), used for the game-over screen.
- Without it: the dim port exists but is ignored, and there is no shift logic.

Decomposition:
- Package bkg_pkg holds:
  - IMG_W, IMG_H, SCR_W=640, SCR_H=480, TILE=320
  - typedef rgb_t (24-bit packed struct {r,g,b})
  - typedef coord_t (10 bits)
- One natural sub-module: bkg_addr_gen, the combinational wrap/scale/multiply-by-160 from (DrawX, DrawY, offset) to address, unit-testable on its own.

Test Plan:
- Reset held 2 cycles with DrawX=100 -> all outputs 0, scroll_offset=0; after release, first valid bkg_rgb appears 3 cycles later.
- offset=0, DrawX=5, DrawY=3 -> read_address=162. RAM model returns AABBCC with blank=1 -> bkg_rgb=AABBCC 3 cycles after input. Same pixel with blank=0 -> bkg_rgb=0.
- DrawX=330, DrawY=0 -> x_img=5, read_address=5; DrawX=639 -> x_img=159.
- offset=0, scroll_amt=10, VS 1->0 -> scroll_offset=310 one cycle after APPLY. VS held low 100 cycles -> no further change. Then DrawY=20 -> ys=10, y_img=5, read_address=800.
- offset=310, DrawY=479, DrawX=0 -> ys=789-640=149, y_img=74, read_address=11840.
- BKG_DIM_EN build: dim=1, ram_data=FF8040 -> bkg_rgb=7F4020. Non-dim build: same stimulus -> bkg_rgb=FF8040.
